// File: rtl/jtopll_wrq_pkg.sv
// jtopll_wrq_pkg: shared types and default timing for the OPLL register-write scheduler.
package jtopll_wrq_pkg;

    typedef struct packed {
        logic [7:0] reg_idx;
        logic [7:0] data;
    } wrq_entry_t;

    typedef enum logic [2:0] {
        IDLE,
        AWR,
        AWAIT,
        DWR,
        DWAIT
    } wrq_state_t;

    localparam int DEF_FIFO_AW   = 2;
    localparam int DEF_ADDR_WAIT = 12;
    localparam int DEF_DATA_WAIT = 84;

endpackage

// File: rtl/jtopll_wrq_fifo.sv
// jtopll_wrq_fifo: sync FIFO of pending register writes.
// With JTOPLL_WRQ_COALESCE_EN a lookup port finds a queued entry with the same register.
module jtopll_wrq_fifo
    import jtopll_wrq_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  wrq_entry_t din_i,
    output wrq_entry_t dout_o,
    output logic       full_o,
    output logic       empty_o
`ifdef JTOPLL_WRQ_COALESCE_EN
    ,
    input  logic [7:0] lk_reg_i,
    output logic       lk_hit_o
`endif
);
    localparam int D = 1 << AW;

    wrq_entry_t    mem_q [D];
    logic [AW:0]   wr_q, rd_q;
    logic          hit;
    logic [AW-1:0] hit_idx;

    assign empty_o = wr_q == rd_q;
    assign full_o  = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
    assign dout_o  = mem_q[rd_q[AW-1:0]];

`ifdef JTOPLL_WRQ_COALESCE_EN
    logic [AW:0]   used;
    logic [AW-1:0] slot;

    assign used     = wr_q - rd_q;
    assign lk_hit_o = hit;

    // The head is excluded while it is being popped: its old data is already leaving.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        slot    = '0;
        for (int i = 0; i < D; i++) begin
            slot = rd_q[AW-1:0] + AW'(i);
            if (i < int'(used) && !(pop_i && i == 0) && mem_q[slot].reg_idx == lk_reg_i) begin
                hit     = 1'b1;
                hit_idx = slot;
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i && !hit) wr_q <= wr_q + 1'b1;
            if (pop_i) rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[hit ? hit_idx : wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/jtopll_wrq.sv
// jtopll_wrq: round-robin write arbiter, FIFO and timed address/data replay to the OPLL bus.
// Optional JTOPLL_WRQ_COALESCE_EN merges a write into a queued entry for the same register.
module jtopll_wrq
    import jtopll_wrq_pkg::*;
#(
    parameter int FIFO_AW   = DEF_FIFO_AW,
    parameter int ADDR_WAIT = DEF_ADDR_WAIT,
    parameter int DATA_WAIT = DEF_DATA_WAIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_reg,
    input  logic [7:0] req0_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_reg,
    input  logic [7:0] req1_data,
    output logic [7:0] opll_din,
    output logic       opll_addr,
    output logic       opll_cs_n,
    output logic       opll_wr_n,
    output logic       busy,
    output logic       ovf
);
    localparam int CW = $clog2(DATA_WAIT) + 1;

    wrq_state_t    st_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    data_q, din_q, stall_q;
    logic          addr_q, strobe_n_q, rr_q, ovf_q;
    logic          sel, any_v, room, acc, hit, full, empty, pop, stall;
    wrq_entry_t    sel_e, head;

    // sel=1 picks req1; rr_q=1 hands priority to req1 when both are valid
    assign any_v      = req0_valid | req1_valid;
    assign sel        = req1_valid & (~req0_valid | rr_q);
    assign sel_e      = sel ? {req1_reg, req1_data} : {req0_reg, req0_data};
    assign room       = ~full | pop | hit;
    assign acc        = any_v & room & rst_n;
    assign req0_ready = acc & ~sel;
    assign req1_ready = acc & sel;
    assign stall      = any_v & ~room;
    assign pop        = ~empty & ((st_q == IDLE) | ((st_q == DWAIT) & cen & (cnt_q == '0)));
    assign busy       = ~empty | (st_q != IDLE);

    assign opll_din  = din_q;
    assign opll_addr = addr_q;
    assign opll_cs_n = strobe_n_q;
    assign opll_wr_n = strobe_n_q;
    assign ovf       = ovf_q;

    jtopll_wrq_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (acc),
        .pop_i   (pop),
        .din_i   (sel_e),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
`ifdef JTOPLL_WRQ_COALESCE_EN
        ,
        .lk_reg_i(sel_e.reg_idx),
        .lk_hit_o(hit)
`endif
    );

`ifndef JTOPLL_WRQ_COALESCE_EN
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_q <= 1'b0;
        else if (acc) rr_q <= ~sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            stall_q <= stall ? ((stall_q == 8'hff) ? stall_q : stall_q + 8'd1) : 8'd0;
            if (stall && stall_q == 8'hff) ovf_q <= 1'b1;
        end
    end

    // A pop always starts the address strobe, both from IDLE and straight out of DWAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            cnt_q      <= '0;
            data_q     <= '0;
            din_q      <= '0;
            addr_q     <= 1'b0;
            strobe_n_q <= 1'b1;
        end else if (pop) begin
            st_q       <= AWR;
            data_q     <= head.data;
            din_q      <= head.reg_idx;
            addr_q     <= 1'b0;
            strobe_n_q <= 1'b0;
        end else if (cen) begin
            case (st_q)
                AWR: begin
                    st_q       <= AWAIT;
                    strobe_n_q <= 1'b1;
                    cnt_q      <= CW'(ADDR_WAIT - 1);
                end
                AWAIT: begin
                    if (cnt_q == '0) begin
                        st_q       <= DWR;
                        din_q      <= data_q;
                        addr_q     <= 1'b1;
                        strobe_n_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DWR: begin
                    st_q       <= DWAIT;
                    strobe_n_q <= 1'b1;
                    cnt_q      <= CW'(DATA_WAIT - 1);
                end
                DWAIT: begin
                    if (cnt_q == '0) st_q <= IDLE;
                    else cnt_q <= cnt_q - 1'b1;
                end
                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtopll_wrq.sv
// tb_jtopll_wrq: directed self-checking bench for jtopll_wrq (define JTOPLL_WRQ_COALESCE_EN for the merge case).
module tb_jtopll_wrq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cen;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_reg, req0_data, req1_reg, req1_data;
    logic [7:0] opll_din;
    logic       opll_addr, opll_cs_n, opll_wr_n, busy, ovf;

    int   total = 0;
    int   bad = 0;
    bit   div = 1'b0;
    bit   cen_lvl = 1'b1;
    logic [8:0] mon[$];

    int   n;
    bit   ok, g0, g1;
    int   gs[$];
    int   exp_g[4] = '{0, 1, 0, 1};
    logic [8:0] exp_w[8] = '{9'h020, 9'h101, 9'h030, 9'h102, 9'h020, 9'h103, 9'h030, 9'h104};

    jtopll_wrq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_reg  (req0_reg),
        .req0_data (req0_data),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_reg  (req1_reg),
        .req1_data (req1_data),
        .opll_din  (opll_din),
        .opll_addr (opll_addr),
        .opll_cs_n (opll_cs_n),
        .opll_wr_n (opll_wr_n),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        int ph;
        ph  = 0;
        cen = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cen = div ? (ph % 4 == 3) : cen_lvl;
            ph++;
        end
    end

    // One record per strobe: the cen-qualified edge inside AWR/DWR
    always @(posedge clk) if (rst_n && cen && !opll_cs_n) mon.push_back({opll_addr, opll_din});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mon.delete();
    endtask

    task automatic push(input bit ch, input logic [7:0] r, input logic [7:0] d);
        int k;
        if (ch) begin req1_valid = 1'b1; req1_reg = r; req1_data = d; end
        else begin req0_valid = 1'b1; req0_reg = r; req0_data = d; end
        #1;
        k = 0;
        while (!(ch ? req1_ready : req0_ready) && k < 1000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("push_ready", ch ? req1_ready : req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_low(output int k, output bit st);
        logic [7:0] d;
        d  = opll_din;
        st = 1'b1;
        k  = 0;
        while (opll_cs_n && k < 2000) begin
            @(negedge clk);
            k++;
            if (opll_cs_n && opll_din !== d) st = 1'b0;
        end
    endtask

    task automatic wait_high(output int k);
        k = 0;
        while (!opll_cs_n && k < 2000) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_reg = 8'h10; req0_data = 8'h55;
        req1_valid = 1'b0; req1_reg = 8'h00; req1_data = 8'h00;
        #12;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_din", opll_din, 0);
        chk("rst_addr", opll_addr, 0);
        chk("rst_cs_n", opll_cs_n, 1);
        chk("rst_wr_n", opll_wr_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        req0_valid = 1'b0;
        @(negedge clk);
        do_reset();

        // single write, cen=1: 1 + 12 + 1 + 84 cycles
        push(0, 8'h10, 8'h55);
        chk("t1_busy", busy, 1);
        wait_low(n, ok);
        chk("t1_alat", n, 1);
        chk("t1_adin", opll_din, 8'h10);
        chk("t1_aaddr", opll_addr, 0);
        chk("t1_awr_n", opll_wr_n, 0);
        wait_high(n);
        chk("t1_awidth", n, 1);
        wait_low(n, ok);
        chk("t1_await", n, 12);
        chk("t1_astable", ok, 1);
        chk("t1_ddin", opll_din, 8'h55);
        chk("t1_daddr", opll_addr, 1);
        wait_high(n);
        chk("t1_dwidth", n, 1);
        wait_idle(n);
        chk("t1_dwait", n, 84);
        chk("t1_nrec", mon.size(), 2);

        // round robin with both requesters valid
        do_reset();
        req0_reg = 8'h20; req0_data = 8'h01; req1_reg = 8'h30; req1_data = 8'h02;
        req0_valid = 1'b1; req1_valid = 1'b1;
        gs.delete();
        n = 0;
        while (gs.size() < 4 && n < 100) begin
            #1;
            g0 = req0_ready;
            g1 = req1_ready;
            @(posedge clk);
            #1;
            if (g0) begin gs.push_back(0); req0_data += 8'd2; end
            if (g1) begin gs.push_back(1); req1_data += 8'd2; end
            @(negedge clk);
            n++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_count", gs.size(), 4);
        for (int i = 0; i < gs.size() && i < 4; i++) chk($sformatf("rr_grant%0d", i), gs[i], exp_g[i]);
        n = 0;
        while (mon.size() < 8 && n < 2000) begin @(negedge clk); n++; end
        chk("rr_nrec", mon.size(), 8);
        for (int i = 0; i < mon.size() && i < 8; i++) chk($sformatf("rr_bus%0d", i), mon[i], exp_w[i]);

        // cen one in four
        div = 1'b1;
        do_reset();
        push(0, 8'h40, 8'h77);
        wait_low(n, ok);
        wait_high(n);
        wait_low(n, ok);
        chk("cd_await", n, 48);
        chk("cd_astable", ok, 1);
        chk("cd_ddin", opll_din, 8'h77);
        wait_high(n);
        chk("cd_dwidth", n, 4);
        wait_idle(n);
        chk("cd_dwait", n, 336);
        div = 1'b0;
        cen_lvl = 1'b1;

        // FIFO full while FSM is frozen in AWR, then stall counter to ovf
        cen_lvl = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) push(0, 8'h50 + 8'(i), 8'ha0 + 8'(i));
        chk("ff_busy", busy, 1);
        chk("ff_stretch", opll_cs_n, 0);
        req0_valid = 1'b1; req0_reg = 8'h55; req0_data = 8'ha5;
        #1;
        chk("ff_notready", req0_ready, 0);
        repeat (255) @(negedge clk);
        chk("ff_ovf255", ovf, 0);
        @(negedge clk);
        chk("ff_ovf256", ovf, 1);
        chk("ff_held", req0_ready, 0);
        cen_lvl = 1'b1;
        n = 0;
        while (!req0_ready && n < 400) begin @(negedge clk); #1; n++; end
        chk("ff_accept", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        chk("ff_sticky", ovf, 1);
        n = 0;
        while (mon.size() < 12 && n < 2000) begin @(negedge clk); n++; end
        chk("ff_nrec", mon.size(), 12);
        for (int i = 0; i < mon.size() / 2 && i < 6; i++) begin
            chk($sformatf("ff_reg%0d", i), mon[2*i], {1'b0, 8'h50 + 8'(i)});
            chk($sformatf("ff_dat%0d", i), mon[2*i+1], {1'b1, 8'ha0 + 8'(i)});
        end

        // reset while the address strobe is held low
        cen_lvl = 1'b0;
        do_reset();
        push(0, 8'h66, 8'h99);
        push(0, 8'h67, 8'h98);
        chk("ra_cs_low", opll_cs_n, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_cs_n", opll_cs_n, 1);
        chk("ra_wr_n", opll_wr_n, 1);
        chk("ra_busy", busy, 0);
        cen_lvl = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("ra_idle", busy, 0);
        chk("ra_nrec", mon.size(), 0);

        // reset during AWAIT
        do_reset();
        push(0, 8'h68, 8'h97);
        push(0, 8'h69, 8'h96);
        wait_low(n, ok);
        wait_high(n);
        repeat (3) @(negedge clk);
        chk("rw_din_pre", opll_din, 8'h68);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_din", opll_din, 0);
        chk("rw_cs_n", opll_cs_n, 1);
        chk("rw_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rw_idle", busy, 0);

`ifdef JTOPLL_WRQ_COALESCE_EN
        cen_lvl = 1'b0;
        do_reset();
        push(0, 8'h60, 8'h11);
        push(0, 8'h10, 8'haa);
        push(1, 8'h10, 8'hbb);
        cen_lvl = 1'b1;
        repeat (2) @(negedge clk);
        wait_idle(n);
        chk("co_nrec", mon.size(), 4);
        if (mon.size() >= 4) begin
            chk("co_reg", mon[2], 9'h010);
            chk("co_dat", mon[3], 9'h1bb);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
